// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Contents: FSM state encoding, bytes-per-word constant, word-address helper.
// Build option: LOADER_CHECKSUM_EN enables the trailing XOR checksum byte (StCsum).
package program_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam int unsigned BytesPerWord = 4;

  // Word address of a given image index; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Byte-to-word assembler for the program loader.
// Shifts stream bytes MSB-first into a 32-bit word and strobes on the 4th byte.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   clear_i         drop any partial word and restart the byte count
//   shift_i         accepted byte this cycle
//   byte_i          stream byte
//   word_o          word including the current byte (valid when word_ready_o is high)
//   word_ready_o    current byte completes a word
module program_loader_byte_assembler
  import program_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  localparam logic [1:0] LastByte = 2'(BytesPerWord - 1);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (shift_i) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= {word_q[23:0], byte_i};
    end
  end

  // Presented combinationally so the FSM can act in the same cycle as the 4th byte.
  assign word_o       = {word_q[23:0], byte_i};
  assign word_ready_o = shift_i && (cnt_q == LastByte);

endmodule

// File: rtl/program_loader.sv
// Program loader: writer side of instruction memory.
// Receives a byte stream (valid/ready): 4-byte word count N, then N words, all MSB first.
// Issues single-cycle we/address/data writes and holds the fetch stage while loading.
// Build option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte over header and data.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   start_i         begin a load from idle, done or error; ignored while loading
//   byte_valid_i    byte_data_i valid
//   byte_data_i     stream byte
//   byte_ready_o    loader accepts a byte this cycle
//   we_o            instruction-memory write enable, one cycle per word
//   address_o       instruction-memory word address
//   data_o          instruction word
//   cpu_hold_o      load in progress; freezes the PC
//   done_o          image loaded without error (sticky until start/reset)
//   error_o         load failed (sticky until start/reset)
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'd0,
  parameter int unsigned MaxWords = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        we_o,
  output logic [31:0] address_o,
  output logic [31:0] data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        error_o
);

  localparam logic [31:0] MaxWordsW = 32'(MaxWords);

  state_e      state_q;
  logic [31:0] n_q;
  logic [31:0] index_q;
  logic        ready_q;
  logic        we_q;
  logic [31:0] address_q;
  logic [31:0] data_q;
  logic        hold_q;
  logic        done_q;
  logic        error_q;

  logic        xfer;
  logic        start_ok;
  logic [31:0] word;
  logic        word_ready;

  assign xfer     = byte_valid_i && ready_q;
  assign start_ok = start_i && (state_q == StIdle || state_q == StDone || state_q == StErr);

  program_loader_byte_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (start_ok),
    .shift_i      (xfer),
    .byte_i       (byte_data_i),
    .word_o       (word),
    .word_ready_o (word_ready)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of header and data bytes; the trailing checksum byte itself is excluded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (xfer && (state_q == StLen || state_q == StData)) begin
      csum_q <= csum_q ^ byte_data_i;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      n_q       <= '0;
      index_q   <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      address_q <= BaseAddr;
      data_q    <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        StIdle, StDone, StErr: begin
          if (start_ok) begin
            state_q <= StLen;
            index_q <= '0;
            ready_q <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        StLen: begin
          if (word_ready) begin
            n_q <= word;
            if (word > MaxWordsW) begin
              state_q <= StErr;
              ready_q <= 1'b0;
              hold_q  <= 1'b0;
              error_q <= 1'b1;
            end else if (word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= StCsum;
`else
              state_q <= StDone;
              ready_q <= 1'b0;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (word_ready) begin
            state_q   <= StWrite;
            ready_q   <= 1'b0;
            we_q      <= 1'b1;
            address_q <= word_addr(BaseAddr, index_q);
            data_q    <= word;
          end
        end
        StWrite: begin
          index_q <= index_q + 32'd1;
          if (index_q + 32'd1 == n_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_q <= StCsum;
            ready_q <= 1'b1;
`else
            state_q <= StDone;
            hold_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else begin
            state_q <= StData;
            ready_q <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StCsum: begin
          if (xfer) begin
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            if (byte_data_i == csum_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StErr;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready_o = ready_q;
  assign we_o         = we_q;
  assign address_o    = address_q;
  assign data_o       = data_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  localparam logic [31:0] WrapBase = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  bdata = 8'h00;

  logic        rdy0, we0, hold0, done0, err0;
  logic [31:0] addr0, data0;
  logic        rdy1, we1, hold1, done1, err1;
  logic [31:0] addr1, data1;

  always #5 clk = ~clk;

  program_loader #(.BaseAddr(32'd0), .MaxWords(256)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .byte_valid_i(valid), .byte_data_i(bdata),
    .byte_ready_o(rdy0), .we_o(we0), .address_o(addr0), .data_o(data0),
    .cpu_hold_o(hold0), .done_o(done0), .error_o(err0)
  );

  // Same stream, base address at the top of the space to exercise wrap-around.
  program_loader #(.BaseAddr(WrapBase), .MaxWords(256)) dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(start), .byte_valid_i(valid), .byte_data_i(bdata),
    .byte_ready_o(rdy1), .we_o(we1), .address_o(addr1), .data_o(data1),
    .cpu_hold_o(hold1), .done_o(done1), .error_o(err1)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] n;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          gap;
    bit          start_mid;
    bit          trail_bad;
    bit          hdr_err;
  } vec_t;

  wr_t q0[$];
  wr_t q1[$];
  int  checks = 0;
  int  failures = 0;
  bit  gap_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write pops the oldest expected write of its instance.
  always @(negedge clk) begin
    wr_t e;
    if (we0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write dut: addr %h data %h, none expected", addr0, data0);
      end else begin
        e = q0.pop_front();
        if (addr0 !== e.a || data0 !== e.d) begin
          failures++;
          $display("FAIL write dut: got %h/%h expected %h/%h", addr0, data0, e.a, e.d);
        end
      end
      chk("ready_during_we", {31'd0, rdy0}, 32'd0);
    end
    if (we1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write dut_w: addr %h data %h, none expected", addr1, data1);
      end else begin
        e = q1.pop_front();
        if (addr1 !== e.a || data1 !== e.d) begin
          failures++;
          $display("FAIL write dut_w: got %h/%h expected %h/%h", addr1, data1, e.a, e.d);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    if (gap_mode) begin
      valid = 1'b0;
      @(negedge clk);
    end
    valid = 1'b1;
    bdata = b;
    while (!rdy0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: byte %h not accepted within 50 cycles", b);
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit mid, inout logic [7:0] x);
    for (int i = 3; i >= 0; i--) begin
      logic [7:0] b;
      b = w[i*8 +: 8];
      x = x ^ b;
      send_byte(b);
      if (mid && i == 3) pulse_start();
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, {31'd0, rdy0}, 32'd0);
    chk({tag, "_we"}, {31'd0, we0}, 32'd0);
    chk({tag, "_hold"}, {31'd0, hold0}, 32'd0);
    chk({tag, "_done"}, {31'd0, done0}, 32'd0);
    chk({tag, "_error"}, {31'd0, err0}, 32'd0);
    chk({tag, "_address"}, addr0, 32'd0);
    chk({tag, "_data"}, data0, 32'd0);
    chk({tag, "_address_w"}, addr1, WrapBase);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] x;
    logic [31:0] ws [2];
    bit exp_err;
    int t;
    x = 8'h00;
    ws[0] = v.w0;
    ws[1] = v.w1;
    exp_err = v.hdr_err || (CsumEn && v.trail_bad);
    gap_mode = v.gap;
    pulse_start();
    chk($sformatf("v%0d_hold_at_start", idx), {31'd0, hold0}, 32'd1);
    chk($sformatf("v%0d_ready_at_start", idx), {31'd0, rdy0}, 32'd1);
    chk($sformatf("v%0d_done_cleared", idx), {30'd0, done0, err0}, 32'd0);
    send_word(v.n, 1'b0, x);
    if (!v.hdr_err) begin
      for (int i = 0; i < v.nw; i++) begin
        q0.push_back('{a: 32'd0 + 32'(i), d: ws[i]});
        q1.push_back('{a: WrapBase + 32'(i), d: ws[i]});
        send_word(ws[i], v.start_mid && i == 0, x);
      end
      if (CsumEn) send_byte(v.trail_bad ? (x ^ 8'h05) : x);
    end
    t = 0;
    while (!(done0 || err0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("v%0d_done", idx), {31'd0, done0}, {31'd0, !exp_err});
    chk($sformatf("v%0d_error", idx), {31'd0, err0}, {31'd0, exp_err});
    chk($sformatf("v%0d_hold_end", idx), {31'd0, hold0}, 32'd0);
    chk($sformatf("v%0d_done_w", idx), {31'd0, done1}, {31'd0, !exp_err});
    chk($sformatf("v%0d_writes_left", idx), 32'(q0.size() + q1.size()), 32'd0);
    gap_mode = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    logic [7:0] x;
    vecs[0] = '{n: 32'd2, nw: 2, w0: 32'h1234_5678, w1: 32'hDEAD_BEEF,
                gap: 0, start_mid: 0, trail_bad: 0, hdr_err: 0};
    vecs[1] = '{n: 32'd2, nw: 2, w0: 32'h1234_5678, w1: 32'hDEAD_BEEF,
                gap: 1, start_mid: 0, trail_bad: 0, hdr_err: 0};
    vecs[2] = '{n: 32'd257, nw: 0, w0: 32'h0, w1: 32'h0,
                gap: 0, start_mid: 0, trail_bad: 0, hdr_err: 1};
    vecs[3] = '{n: 32'd2, nw: 2, w0: 32'hCAFE_F00D, w1: 32'h0BAD_C0DE,
                gap: 0, start_mid: 1, trail_bad: 0, hdr_err: 0};
    vecs[4] = '{n: 32'd1, nw: 1, w0: 32'h0102_0304, w1: 32'h0,
                gap: 0, start_mid: 0, trail_bad: 0, hdr_err: 0};
    vecs[5] = '{n: 32'd1, nw: 1, w0: 32'h0102_0304, w1: 32'h0,
                gap: 1, start_mid: 0, trail_bad: 1, hdr_err: 0};
    vecs[6] = '{n: 32'd0, nw: 0, w0: 32'h0, w1: 32'h0,
                gap: 0, start_mid: 0, trail_bad: 0, hdr_err: 0};

    repeat (3) @(negedge clk);
    check_reset_values("in_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("after_reset");

    // Reset mid-stream: header for two words, then only half of the first word.
    pulse_start();
    x = 8'h00;
    send_word(32'd2, 1'b0, x);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_reset_no_write", {31'd0, we0}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Error must be visible right after the 4th header byte.
    pulse_start();
    x = 8'h00;
    send_word(32'd300, 1'b0, x);
    @(negedge clk);
    chk("big_hdr_error_now", {31'd0, err0}, 32'd1);
    chk("big_hdr_ready_low", {31'd0, rdy0}, 32'd0);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
